// File: rtl/riscv_decode_arb_pkg.sv
// rtl/riscv_decode_arb_pkg.sv - shared widths, slot layout and packing helper for the decode arbiter
package riscv_decode_arb_pkg;

  localparam int HART_W            = 1;
  localparam int CNT_W             = 4;
  localparam int DEFAULT_MAX_BURST = 4;

  // Slot vector layout: {valid, fault_page, fault_fetch, instr, pc}
  localparam int PC_LSB          = 0;
  localparam int INSTR_LSB       = 32;
  localparam int FAULT_FETCH_BIT = 64;
  localparam int FAULT_PAGE_BIT  = 65;
  localparam int VALID_BIT       = 66;
  localparam int SLOT_W          = 67;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [HART_W-1:0] hart_t;

  function automatic slot_t pack_slot(input logic        fault_page,
                                      input logic        fault_fetch,
                                      input logic [31:0] instr,
                                      input logic [31:0] pc);
    logic [31:0] instr_z;
    instr_z   = (fault_page | fault_fetch) ? 32'h0 : instr;
    pack_slot = {1'b1, fault_page, fault_fetch, instr_z, pc};
  endfunction

endpackage

// File: rtl/riscv_decode_arbiter_if.sv
// rtl/riscv_decode_arbiter_if.sv - fetch, squash and decode-slot signals shared by both harts
interface riscv_decode_arbiter_if;
  import riscv_decode_arb_pkg::*;

  logic        fetch0_valid_i;
  logic [31:0] fetch0_instr_i;
  logic [31:0] fetch0_pc_i;
  logic        fetch0_fault_fetch_i;
  logic        fetch0_fault_page_i;
  logic        fetch0_accept_o;
  logic        squash0_i;

  logic        fetch1_valid_i;
  logic [31:0] fetch1_instr_i;
  logic [31:0] fetch1_pc_i;
  logic        fetch1_fault_fetch_i;
  logic        fetch1_fault_page_i;
  logic        fetch1_accept_o;
  logic        squash1_i;

  logic        decode_valid_o;
  logic [31:0] decode_instr_o;
  logic [31:0] decode_pc_o;
  logic        decode_fault_fetch_o;
  logic        decode_fault_page_o;
  hart_t       decode_hart_o;
  logic        decode_accept_i;

  modport master (
    output fetch0_valid_i, fetch0_instr_i, fetch0_pc_i, fetch0_fault_fetch_i, fetch0_fault_page_i, squash0_i,
    output fetch1_valid_i, fetch1_instr_i, fetch1_pc_i, fetch1_fault_fetch_i, fetch1_fault_page_i, squash1_i,
    output decode_accept_i,
    input  fetch0_accept_o, fetch1_accept_o,
    input  decode_valid_o, decode_instr_o, decode_pc_o, decode_fault_fetch_o, decode_fault_page_o, decode_hart_o
  );

  modport slave (
    input  fetch0_valid_i, fetch0_instr_i, fetch0_pc_i, fetch0_fault_fetch_i, fetch0_fault_page_i, squash0_i,
    input  fetch1_valid_i, fetch1_instr_i, fetch1_pc_i, fetch1_fault_fetch_i, fetch1_fault_page_i, squash1_i,
    input  decode_accept_i,
    output fetch0_accept_o, fetch1_accept_o,
    output decode_valid_o, decode_instr_o, decode_pc_o, decode_fault_fetch_o, decode_fault_page_o, decode_hart_o
  );

endinterface

// File: rtl/riscv_decode_arb_slot.sv
// rtl/riscv_decode_arb_slot.sv - one-entry decode slot with load, clear (drop valid) and hold
module riscv_decode_arb_slot
  import riscv_decode_arb_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  logic  clear_i,
  input  slot_t slot_i,
  input  hart_t hart_i,
  output slot_t slot_o,
  output hart_t hart_o
);

  slot_t slot_q;
  hart_t hart_q;

  // Clearing only drops valid; stale payload is harmless behind a low valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q <= '0;
      hart_q <= '0;
    end else if (load_i) begin
      slot_q <= slot_i;
      hart_q <= hart_i;
    end else if (clear_i) begin
      slot_q[VALID_BIT] <= 1'b0;
    end
  end

  assign slot_o = slot_q;
  assign hart_o = hart_q;

endmodule

// File: rtl/riscv_decode_arbiter.sv
// rtl/riscv_decode_arbiter.sv - two-hart fetch arbiter with bounded-burst sticky priority feeding one decode slot
module riscv_decode_arbiter
  import riscv_decode_arb_pkg::*;
#(
  parameter int MAX_BURST   = DEFAULT_MAX_BURST,
  parameter int RESET_OWNER = 0
) (
  input logic                   clk_i,
  input logic                   rst_i,
  riscv_decode_arbiter_if.slave bus
);

  logic             req0, req1, both_req, hit, load, grant;
  logic             slot_valid, slot_clear;
  hart_t            sel, owner_q, owner_d, slot_hart;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_t            slot_q, slot_d;

  assign req0     = bus.fetch0_valid_i & ~bus.squash0_i;
  assign req1     = bus.fetch1_valid_i & ~bus.squash1_i;
  assign both_req = req0 & req1;

  assign slot_valid = slot_q[VALID_BIT];
  assign hit        = slot_valid & ((slot_hart == 1'b1) ? bus.squash1_i : bus.squash0_i);
  assign load       = ~slot_valid | bus.decode_accept_i | hit;

  // Owner keeps priority until it has taken MAX_BURST contested grants in a row.
  always_comb begin
    sel = hart_t'(req1);
    if (both_req) begin
      sel = (cnt_q == CNT_W'(MAX_BURST)) ? ~owner_q : owner_q;
    end
  end

  assign grant      = ~rst_i & load & (req0 | req1);
  assign slot_clear = load & ~grant;

  assign bus.fetch0_accept_o = grant & (sel == 1'b0);
  assign bus.fetch1_accept_o = grant & (sel == 1'b1);

  assign slot_d = (sel == 1'b1)
                ? pack_slot(bus.fetch1_fault_page_i, bus.fetch1_fault_fetch_i, bus.fetch1_instr_i, bus.fetch1_pc_i)
                : pack_slot(bus.fetch0_fault_page_i, bus.fetch0_fault_fetch_i, bus.fetch0_instr_i, bus.fetch0_pc_i);

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (grant) begin
      owner_d = sel;
      if (sel == owner_q) begin
        cnt_d = both_req ? cnt_q + CNT_W'(1) : '0;
      end else begin
        cnt_d = both_req ? CNT_W'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= hart_t'(RESET_OWNER);
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  riscv_decode_arb_slot u_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (grant),
    .clear_i (slot_clear),
    .slot_i  (slot_d),
    .hart_i  (sel),
    .slot_o  (slot_q),
    .hart_o  (slot_hart)
  );

  assign bus.decode_valid_o       = slot_valid;
  assign bus.decode_instr_o       = slot_q[INSTR_LSB +: 32];
  assign bus.decode_pc_o          = slot_q[PC_LSB +: 32];
  assign bus.decode_fault_fetch_o = slot_q[FAULT_FETCH_BIT];
  assign bus.decode_fault_page_o  = slot_q[FAULT_PAGE_BIT];
  assign bus.decode_hart_o        = slot_hart;

endmodule

// File: tb/tb_riscv_decode_arbiter.sv
// tb/tb_riscv_decode_arbiter.sv - scoreboard bench for the two-hart decode arbiter
module tb_riscv_decode_arbiter;
  import riscv_decode_arb_pkg::*;

  localparam int MAXB    = 4;
  localparam int RST_OWN = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_decode_arbiter_if bus();

  riscv_decode_arbiter #(.MAX_BURST(MAXB), .RESET_OWNER(RST_OWN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    bit          v;
    bit          s;
    bit          fp;
    bit          ff;
    logic [31:0] instr;
    logic [31:0] pc;
  } freq_t;

  typedef struct {
    bit a0;
    bit a1;
    bit v;
  } cyc_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          fp;
    bit          ff;
    bit          h;
  } ent_t;

  cyc_t cyc_q[$];
  ent_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   seq    = 0;

  // Reference state: what the decode slot holds, and who owns priority with how long a contested run
  bit   mv   = 1'b0;
  bit   mh   = 1'b0;
  bit   mown = 1'(RST_OWN);
  int   mrun = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic freq_t mk(input bit v, input bit s, input int h);
    freq_t f;
    f.v     = v;
    f.s     = s;
    f.fp    = ($urandom_range(0, 9) == 0);
    f.ff    = ($urandom_range(0, 9) == 0);
    f.instr = $urandom;
    f.pc    = (h == 1 ? 32'h8000_0000 : 32'h0000_0000) | 32'(seq * 4);
    return f;
  endfunction

  task automatic drive(input bit r, input bit acc, input freq_t f0, input freq_t f1);
    bit    r0, r1, contested, hit, ld;
    int    g;
    cyc_t  c;
    ent_t  e;
    freq_t f;
    @(posedge clk);
    #1;
    seq++;
    rst                      = r;
    bus.decode_accept_i      = acc;
    bus.fetch0_valid_i       = f0.v;
    bus.squash0_i            = f0.s;
    bus.fetch0_fault_page_i  = f0.fp;
    bus.fetch0_fault_fetch_i = f0.ff;
    bus.fetch0_instr_i       = f0.instr;
    bus.fetch0_pc_i          = f0.pc;
    bus.fetch1_valid_i       = f1.v;
    bus.squash1_i            = f1.s;
    bus.fetch1_fault_page_i  = f1.fp;
    bus.fetch1_fault_fetch_i = f1.ff;
    bus.fetch1_instr_i       = f1.instr;
    bus.fetch1_pc_i          = f1.pc;

    r0        = f0.v && !f0.s;
    r1        = f1.v && !f1.s;
    contested = r0 && r1;
    hit       = mv && (mh ? f1.s : f0.s);
    ld        = !mv || acc || hit;
    g         = -1;
    if (!r && ld) begin
      if (contested) g = (mrun == MAXB) ? int'(!mown) : int'(mown);
      else if (r0)   g = 0;
      else if (r1)   g = 1;
    end

    c.a0 = (g == 0);
    c.a1 = (g == 1);
    c.v  = mv;
    cyc_q.push_back(c);

    if (hit && exp_q.size() > 0) void'(exp_q.pop_front());

    if (r) begin
      mv   = 1'b0;
      mown = 1'(RST_OWN);
      mrun = 0;
      exp_q.delete();
    end else if (g >= 0) begin
      if (g == 1) f = f1;
      else        f = f0;
      e.pc    = f.pc;
      e.instr = (f.fp || f.ff) ? 32'h0 : f.instr;
      e.fp    = f.fp;
      e.ff    = f.ff;
      e.h     = (g == 1);
      exp_q.push_back(e);
      mrun = contested ? ((g == int'(mown)) ? mrun + 1 : 1) : 0;
      mown = (g == 1);
      mv   = 1'b1;
      mh   = (g == 1);
    end else if (ld) begin
      mv = 1'b0;
    end
  endtask

  initial begin
    cyc_t c;
    ent_t e;
    bit   hit;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("fetch0_accept", 32'(bus.fetch0_accept_o), 32'(c.a0));
        chk("fetch1_accept", 32'(bus.fetch1_accept_o), 32'(c.a1));
        chk("decode_valid",  32'(bus.decode_valid_o),  32'(c.v));
        hit = bus.decode_valid_o && (bus.decode_hart_o ? bus.squash1_i : bus.squash0_i);
        if (bus.decode_valid_o && bus.decode_accept_i && !hit && !rst) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL slot_unexpected: got pc %08h expected no entry", bus.decode_pc_o);
          end else begin
            e = exp_q.pop_front();
            chk("decode_pc",          bus.decode_pc_o,                 e.pc);
            chk("decode_instr",       bus.decode_instr_o,              e.instr);
            chk("decode_fault_page",  32'(bus.decode_fault_page_o),    32'(e.fp));
            chk("decode_fault_fetch", 32'(bus.decode_fault_fetch_o),   32'(e.ff));
            chk("decode_hart",        32'(bus.decode_hart_o),          32'(e.h));
          end
        end
      end
    end
  end

  initial begin
    freq_t a, b, idle;
    bit    acc;
    rst                      = 1'b1;
    bus.decode_accept_i      = 1'b0;
    bus.fetch0_valid_i       = 1'b0;
    bus.squash0_i            = 1'b0;
    bus.fetch0_fault_page_i  = 1'b0;
    bus.fetch0_fault_fetch_i = 1'b0;
    bus.fetch0_instr_i       = '0;
    bus.fetch0_pc_i          = '0;
    bus.fetch1_valid_i       = 1'b0;
    bus.squash1_i            = 1'b0;
    bus.fetch1_fault_page_i  = 1'b0;
    bus.fetch1_fault_fetch_i = 1'b0;
    bus.fetch1_instr_i       = '0;
    bus.fetch1_pc_i          = '0;
    idle = mk(0, 0, 0);

    // Reset with both harts requesting: nothing may be accepted
    drive(1, 0, mk(1, 0, 0), mk(1, 0, 1));
    drive(1, 0, mk(1, 0, 0), mk(1, 0, 1));
    @(negedge clk);
    chk("reset_valid",       32'(bus.decode_valid_o),       0);
    chk("reset_instr",       bus.decode_instr_o,            0);
    chk("reset_pc",          bus.decode_pc_o,               0);
    chk("reset_fault_fetch", 32'(bus.decode_fault_fetch_o), 0);
    chk("reset_fault_page",  32'(bus.decode_fault_page_o),  0);
    chk("reset_hart",        32'(bus.decode_hart_o),        0);

    drive(0, 1, idle, mk(1, 0, 1));

    repeat (16) drive(0, 1, mk(1, 0, 0), mk(1, 0, 1));

    repeat (10) drive(0, 1, mk(1, 0, 0), idle);
    repeat (8)  drive(0, 1, mk(1, 0, 0), mk(1, 0, 1));

    // Backpressure on a held hart 0 entry, then release
    drive(0, 1, idle, idle);
    a = mk(1, 0, 0); a.pc = 32'h100; a.fp = 0; a.ff = 0;
    drive(0, 1, a, idle);
    repeat (3) drive(0, 0, mk(1, 0, 0), mk(1, 0, 1));
    drive(0, 1, mk(1, 0, 0), idle);

    // Squash of a hart 1 slot refilled by hart 0, then double squash
    drive(0, 1, idle, mk(1, 0, 1));
    a = mk(1, 0, 0); a.pc = 32'h200;
    drive(0, 0, a, mk(1, 1, 1));
    drive(0, 1, mk(1, 1, 0), mk(1, 1, 1));
    drive(0, 1, idle, idle);

    a = mk(1, 0, 0); a.instr = 32'h0000_0013; a.fp = 1; a.ff = 0;
    drive(0, 1, a, idle);
    drive(0, 1, idle, idle);

    for (int i = 0; i < 3000; i++) begin
      a   = mk($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 0);
      b   = mk($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 1);
      acc = $urandom_range(0, 9) < 7;
      if (i == 1500) drive(1, 0, a, b);
      else           drive(0, acc, a, b);
    end

    repeat (4) drive(0, 1, idle, idle);
    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
